// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket front-end and the downstream counter stage.
package ticket_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [3:0] NUM_MIN = 4'd1;
    localparam logic [3:0] NUM_MAX = 4'd15;

    localparam int TMIN_DEF = 1;
    localparam int TMAX_DEF = 7;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter, rising-edge request pulse.
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYC - 1);

    logic        r_sync0;
    logic        r_sync1;
    logic        r_db;
    logic        r_db_d;
    logic [15:0] r_cnt;

    // The counter only runs while the synchronized input disagrees with the debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= btn;
            r_sync1 <= r_sync0;
            r_db_d  <= r_db;
            if (r_sync1 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign req = r_db & ~r_db_d;

endmodule

// File: rtl/ticket_issuer.sv
// Turns a debounced button press plus a service-time selector into one numbered ticket,
// holding a single press while the queue is full and dropping any further presses.
module ticket_issuer
    import ticket_pkg::*;
#(
    parameter int DEB_CYC = 16,
    parameter int TMIN    = TMIN_DEF,
    parameter int TMAX    = TMAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic [3:0] sel_time,
    input  logic       fifo_full,
    output logic       out_valid,
    output logic [3:0] out_num,
    output logic [3:0] out_time,
    output logic       pending,
    output logic       drop,
    output logic [3:0] next_num
);

    localparam logic [3:0] T_LO = 4'(TMIN);
    localparam logic [3:0] T_HI = 4'(TMAX);

    function automatic logic [3:0] clamp_time(input logic [3:0] t);
        if (t < T_LO)
            return T_LO;
        else if (t > T_HI)
            return T_HI;
        else
            return t;
    endfunction

    function automatic logic [3:0] inc_num(input logic [3:0] n);
        return (n == NUM_MAX) ? NUM_MIN : n + 4'd1;
    endfunction

    logic       w_req;
    logic [3:0] w_time_clamped;
    state_t     r_state;
    logic [3:0] r_time_lat;
    logic [3:0] r_next_num;
    logic       r_valid;
    logic [3:0] r_num;
    logic [3:0] r_out_time;
    logic       r_pending;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .req   (w_req)
    );

    assign w_time_clamped = clamp_time(sel_time);

    // Ticket outputs are loaded on the edge that enters ISSUE, so out_valid is high while in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_next_num <= NUM_MIN;
            r_valid    <= 1'b0;
            r_num      <= 4'd0;
            r_out_time <= 4'd0;
            r_pending  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (fifo_full) begin
                            r_state   <= ST_HOLD;
                            r_pending <= 1'b1;
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_valid    <= 1'b1;
                            r_num      <= r_next_num;
                            r_out_time <= w_time_clamped;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!fifo_full) begin
                        r_state    <= ST_ISSUE;
                        r_pending  <= 1'b0;
                        r_valid    <= 1'b1;
                        r_num      <= r_next_num;
                        r_out_time <= r_time_lat;
                    end
                end
                ST_ISSUE: begin
                    r_state    <= ST_IDLE;
                    r_next_num <= inc_num(r_next_num);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_req)
            r_time_lat <= w_time_clamped;
    end

    assign drop      = (r_state == ST_HOLD) && w_req;
    assign out_valid = r_valid;
    assign out_num   = r_num;
    assign out_time  = r_out_time;
    assign pending   = r_pending;
    assign next_num  = r_next_num;

endmodule

// File: tb/tb_ticket_issuer.sv
// Directed bench for ticket_issuer with a short debounce window.
module tb_ticket_issuer;

    localparam int DEB = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn       = 1'b0;
    logic [3:0] sel_time  = 4'd0;
    logic       fifo_full = 1'b0;
    logic       out_valid;
    logic [3:0] out_num;
    logic [3:0] out_time;
    logic       pending;
    logic       drop;
    logic [3:0] next_num;

    ticket_issuer #(
        .DEB_CYC (DEB),
        .TMIN    (1),
        .TMAX    (7)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .sel_time  (sel_time),
        .fifo_full (fifo_full),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_time  (out_time),
        .pending   (pending),
        .drop      (drop),
        .next_num  (next_num)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ticket recorder: counts strobes and remembers the last ticket seen.
    int         n_tick = 0;
    int         n_drop = 0;
    int         v_cyc  = 0;
    logic [3:0] t_num  = 4'd0;
    logic [3:0] t_time = 4'd0;
    always @(negedge clk) begin
        if (out_valid) begin
            n_tick = n_tick + 1;
            t_num  = out_num;
            t_time = out_time;
            v_cyc  = cyc;
        end
        if (drop) n_drop = n_drop + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int p_cyc    = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn   = 1'b1;
        p_cyc = cyc;
        step(12);
        btn = 1'b0;
        step(12);
    endtask

    task automatic test_reset();
        step(2);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (out_num !== 4'd0) $display("FAIL rst_num got %0d want 0", out_num); else n_pass++;
        n_checks++; if (out_time !== 4'd0) $display("FAIL rst_time got %0d want 0", out_time); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL rst_pending got %0b want 0", pending); else n_pass++;
        n_checks++; if (drop !== 1'b0) $display("FAIL rst_drop got %0b want 0", drop); else n_pass++;
        n_checks++; if (next_num !== 4'd1) $display("FAIL rst_next got %0d want 1", next_num); else n_pass++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_clean();
        int n0;
        int lat;
        n0       = n_tick;
        sel_time = 4'd5;
        press();
        lat = v_cyc - p_cyc;
        n_checks++; if (n_tick - n0 !== 1) $display("FAIL clean_count got %0d want 1", n_tick - n0); else n_pass++;
        n_checks++; if (t_num !== 4'd1) $display("FAIL clean_num got %0d want 1", t_num); else n_pass++;
        n_checks++; if (t_time !== 4'd5) $display("FAIL clean_time got %0d want 5", t_time); else n_pass++;
        n_checks++; if (next_num !== 4'd2) $display("FAIL clean_next got %0d want 2", next_num); else n_pass++;
        n_checks++;
        if (lat < DEB + 3 || lat > DEB + 5) $display("FAIL clean_latency got %0d want %0d..%0d", lat, DEB + 3, DEB + 5);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || out_num !== 4'd1 || out_time !== 4'd5)
            $display("FAIL clean_hold got v=%0b n=%0d t=%0d want v=0 n=1 t=5", out_valid, out_num, out_time);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int n0;
        n0       = n_tick;
        sel_time = 4'd2;
        for (int i = 0; i < 5; i++) begin
            btn = (i % 2 == 0);
            step(2);
        end
        btn = 1'b1;
        step(12);
        btn = 1'b0;
        step(12);
        n_checks++; if (n_tick - n0 !== 1) $display("FAIL bounce_count got %0d want 1", n_tick - n0); else n_pass++;
        n_checks++; if (t_num !== 4'd2) $display("FAIL bounce_num got %0d want 2", t_num); else n_pass++;
    endtask

    task automatic test_clamp();
        sel_time = 4'd0;
        press();
        n_checks++; if (t_time !== 4'd1) $display("FAIL clamp_low got %0d want 1", t_time); else n_pass++;
        n_checks++; if (t_num !== 4'd3) $display("FAIL clamp_low_num got %0d want 3", t_num); else n_pass++;
        sel_time = 4'd12;
        press();
        n_checks++; if (t_time !== 4'd7) $display("FAIL clamp_high got %0d want 7", t_time); else n_pass++;
        n_checks++; if (t_num !== 4'd4) $display("FAIL clamp_high_num got %0d want 4", t_num); else n_pass++;
    endtask

    task automatic test_full();
        int n0;
        int d0;
        int f_cyc;
        n0        = n_tick;
        d0        = n_drop;
        fifo_full = 1'b1;
        sel_time  = 4'd3;
        press();
        n_checks++; if (pending !== 1'b1) $display("FAIL full_pending got %0b want 1", pending); else n_pass++;
        n_checks++; if (n_tick - n0 !== 0) $display("FAIL full_no_ticket got %0d want 0", n_tick - n0); else n_pass++;
        sel_time = 4'd6;
        press();
        n_checks++; if (n_drop - d0 !== 1) $display("FAIL full_drop got %0d want 1", n_drop - d0); else n_pass++;
        n_checks++; if (pending !== 1'b1) $display("FAIL full_still_pending got %0b want 1", pending); else n_pass++;
        fifo_full = 1'b0;
        f_cyc     = cyc;
        step(3);
        n_checks++; if (n_tick - n0 !== 1) $display("FAIL full_release_count got %0d want 1", n_tick - n0); else n_pass++;
        n_checks++; if (t_time !== 4'd3) $display("FAIL full_time got %0d want 3", t_time); else n_pass++;
        n_checks++; if (t_num !== 4'd5) $display("FAIL full_num got %0d want 5", t_num); else n_pass++;
        n_checks++; if (v_cyc !== f_cyc + 1) $display("FAIL full_latency got %0d want %0d", v_cyc - f_cyc, 1); else n_pass++;
        n_checks++; if (pending !== 1'b0) $display("FAIL full_pending_clear got %0b want 0", pending); else n_pass++;
        n_checks++; if (next_num !== 4'd6) $display("FAIL full_next got %0d want 6", next_num); else n_pass++;
    endtask

    task automatic test_hold_reset();
        int n0;
        fifo_full = 1'b1;
        sel_time  = 4'd4;
        press();
        n_checks++; if (pending !== 1'b1) $display("FAIL hrst_pending_before got %0b want 1", pending); else n_pass++;
        #5;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pending !== 1'b0) $display("FAIL hrst_pending got %0b want 0", pending); else n_pass++;
        n_checks++; if (out_num !== 4'd0) $display("FAIL hrst_num got %0d want 0", out_num); else n_pass++;
        n_checks++; if (out_time !== 4'd0) $display("FAIL hrst_time got %0d want 0", out_time); else n_pass++;
        n_checks++; if (next_num !== 4'd1) $display("FAIL hrst_next got %0d want 1", next_num); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hrst_valid got %0b want 0", out_valid); else n_pass++;
        step(1);
        rst_n     = 1'b1;
        fifo_full = 1'b0;
        n0        = n_tick;
        step(5);
        n_checks++; if (n_tick - n0 !== 0) $display("FAIL hrst_no_ticket got %0d want 0", n_tick - n0); else n_pass++;
        sel_time = 4'd9;
        press();
        n_checks++; if (t_num !== 4'd1) $display("FAIL hrst_renum got %0d want 1", t_num); else n_pass++;
        n_checks++; if (t_time !== 4'd7) $display("FAIL hrst_time_after got %0d want 7", t_time); else n_pass++;
    endtask

    task automatic test_wrap();
        int n0;
        logic [3:0] exp_num;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        n0       = n_tick;
        sel_time = 4'd6;
        for (int i = 0; i < 16; i++) begin
            press();
            exp_num = 4'((i % 15) + 1);
            n_checks++;
            if (t_num !== exp_num) $display("FAIL wrap_num[%0d] got %0d want %0d", i, t_num, exp_num);
            else n_pass++;
        end
        n_checks++; if (n_tick - n0 !== 16) $display("FAIL wrap_count got %0d want 16", n_tick - n0); else n_pass++;
        n_checks++; if (next_num !== 4'd2) $display("FAIL wrap_next got %0d want 2", next_num); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_clamp();
        test_full();
        test_hold_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
